// File: rtl/shift_pkg.sv
// Shared types and default sizes for the sequential right shifter.
package shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shr_state_e;

  localparam int SHAMT_W_DEF = 5;
  localparam int WIDTH_DEF   = 32;

endpackage

// File: rtl/shift_right_step.sv
// Combinational right shift by a small amount k (0..STEP), vacated bits taken from fill.
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]             in_data,
  input  logic [$clog2(STEP+1)-1:0]    k,
  input  logic                         fill,
  output logic [WIDTH-1:0]             out_data
);

  // The mask marks the k vacated top positions that must receive the fill bit.
  logic [WIDTH-1:0] fill_mask;

  assign fill_mask = ~({WIDTH{1'b1}} >> k);
  assign out_data  = (in_data >> k) | (fill ? fill_mask : '0);

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle logical/arithmetic right shifter: accepts a request, shifts up to STEP
// bits per cycle, then holds the result until the consumer takes it.
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam int KW = $clog2(STEP + 1);

  shr_state_e         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] rem_after;

  // Never shift past the remaining amount on the final step.
  always_comb begin
    if (int'(rem_q) >= STEP) k = KW'(STEP);
    else                     k = KW'(rem_q);
  end

  assign rem_after = rem_q - SHAMT_W'(k);

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .in_data  (work_q),
    .k        (k),
    .fill     (fill_q),
    .out_data (step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          rem_d   = shift_amount;
          fill_d  = arith & data_in[WIDTH-1];
          state_d = (shift_amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_d = step_out;
        rem_d  = rem_after;
        if (rem_after == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: driver pushes expected results, a monitor pops on handshake.
module tb_shift_right_seq;

  localparam int STEP1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, arith, out_valid, out_ready, busy;
  logic [31:0] data_in, data_out;
  logic [4:0]  shift_amount;

  logic        in_valid4, in_ready4, arith4, out_valid4, out_ready4, busy4;
  logic [31:0] data_in4, data_out4;
  logic [4:0]  shift_amount4;

  always #5 clk = ~clk;

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(STEP1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_amount(shift_amount), .arith(arith),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .data_in(data_in4), .shift_amount(shift_amount4), .arith(arith4),
    .out_valid(out_valid4), .out_ready(out_ready4), .data_out(data_out4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] data;
    int          req_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_txn = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: driven by main sequence

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Consumer ready generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: latency on rising out_valid, hold under backpressure, data on handshake.
  initial begin
    logic        prev_valid, prev_ready;
    logic [31:0] prev_data;
    exp_t        e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) fail_timeout("unexpected out_valid");
          else chk("latency", 32'(cyc - sb[0].req_cyc), 32'(sb[0].lat));
        end
        if (out_valid && prev_valid && !prev_ready)
          chk("hold data_out", data_out, prev_data);
        if (out_valid) chk("in_ready in DONE", {31'b0, in_ready}, 32'd0);
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("data_out", data_out, e.data);
          n_txn++;
          $display("txn %0d: data_out=%h expected=%h cycle=%0d", n_txn, data_out, e.data, cyc);
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = data_out;
      end
    end
  end

  task automatic send(input logic [31:0] d, input int amt, input logic ar, input logic [31:0] exp);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    data_in      = d;
    shift_amount = amt[4:0];
    arith        = ar;
    in_valid     = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) begin
      fail_timeout("accept");
      in_valid = 1'b0;
    end else begin
      sb.push_back('{exp, cyc, (amt + STEP1 - 1) / STEP1 + 1});
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      data_in      = $urandom;
      shift_amount = 5'($urandom);
      arith        = 1'($urandom);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0 || out_valid) fail_timeout("drain");
  endtask

  typedef struct {
    logic [31:0] d;
    int          a;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11] = '{
    '{32'hF000_0000,  4, 1'b0, 32'h0F00_0000},
    '{32'hF000_0000,  4, 1'b1, 32'hFF00_0000},
    '{32'hF000_0000, 31, 1'b1, 32'hFFFF_FFFF},
    '{32'h1234_5678,  0, 1'b0, 32'h1234_5678},
    '{32'h1234_5678,  0, 1'b1, 32'h1234_5678},
    '{32'h8000_0000, 31, 1'b0, 32'h0000_0001},
    '{32'h7FFF_FFFF, 31, 1'b1, 32'h0000_0000},
    '{32'h8765_4321,  8, 1'b1, 32'hFF87_6543},
    '{32'h8765_4321,  8, 1'b0, 32'h0087_6543},
    '{32'h0000_FFFF, 16, 1'b0, 32'h0000_0000},
    '{32'h8000_0001,  1, 1'b1, 32'hC000_0000}
  };

  initial begin
    int          waited, req;
    logic [31:0] d, exp;
    int          a;
    logic        ar;

    in_valid = 1'b0; data_in = '0; shift_amount = '0; arith = 1'b0;
    in_valid4 = 1'b0; data_in4 = '0; shift_amount4 = '0; arith4 = 1'b0; out_ready4 = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy",      {31'b0, busy},      32'd0);
    chk("reset data_out",  data_out,           32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].a, vecs[i].ar, vecs[i].exp);
      drain();
    end

    // Backpressure: result must hold while out_ready is low.
    rdy_mode  = 2;
    out_ready = 1'b0;
    send(32'hF000_0000, 4, 1'b0, 32'h0F00_0000);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) fail_timeout("backpressure out_valid");
    repeat (3) begin
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp busy",      {31'b0, busy},      32'd1);
      chk("bp data_out",  data_out,           32'h0F00_0000);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp release out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp release in_ready",  {31'b0, in_ready},  32'd1);
    rdy_mode = 0;
    drain();

    // Reset in the middle of a long shift discards the request.
    send(32'hDEAD_BEEF, 20, 1'b1, 32'h0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst busy",      {31'b0, busy},      32'd0);
    chk("mid rst data_out",  data_out,           32'd0);
    send(32'h8000_0000, 3, 1'b1, 32'hF000_0000);
    drain();

    // Random operands with random consumer stalls and idle gaps.
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      d   = $urandom;
      a   = int'($urandom_range(0, 31));
      ar  = 1'($urandom_range(0, 1));
      exp = ar ? 32'($signed(d) >>> a) : (d >> a);
      send(d, a, ar, exp);
    end
    drain();
    rdy_mode = 0;

    // STEP=4 instance: amount 13 takes ceil(13/4)+1 cycles.
    @(posedge clk);
    #1;
    data_in4 = 32'h8000_0001; shift_amount4 = 5'd13; arith4 = 1'b1;
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clk);
    chk("step4 in_ready", {31'b0, in_ready4}, 32'd1);
    req = cyc;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid4 && waited < 50);
    if (!out_valid4) fail_timeout("step4 out_valid");
    else begin
      chk("step4 latency", 32'(cyc - req), 32'd5);
      chk("step4 data_out", data_out4, 32'hFFFC_0000);
      $display("txn step4: data_out=%h expected=%h cycle=%0d", data_out4, 32'hFFFC_0000, cyc);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
